// File: rtl/sweep_ctrl.sv
// sweep_ctrl: control stage for an 8-bit loadable up/down counter.
//
// Drives the counter's load/in/dir inputs and watches its output so the counter
// performs a triangle sweep lo -> hi -> lo between bounds programmed through a
// valid/ready handshake. While idle the counter is frozen by a continuous load
// of the held value. Completed sweeps are counted. With SWEEPS != 0 the block
// returns to idle by itself after that many sweeps. SWEEPS = 0 means free-run.
//
// Ports
//   clk          clock, rising edge
//   rstn         asynchronous active-low reset
//   i_cfg_valid  config offer, accepted only in idle
//   o_cfg_ready  config accept, high only in idle
//   i_cfg_lo     lower sweep bound
//   i_cfg_hi     upper sweep bound, must exceed i_cfg_lo
//   i_start      start request, sampled in idle
//   i_stop       abort request while busy
//   i_cnt        counter output fed back
//   o_load       counter load enable (combinational)
//   o_load_val   counter load value
//   o_dir        counter direction, 1 = up (combinational)
//   o_busy       block is not idle
//   o_sweep_done one-cycle pulse per completed sweep (registered)
//   o_err_cfg    sticky flag, set by a rejected config

module sweep_ctrl #(
  parameter int unsigned SWEEPS = 0
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       i_cfg_valid,
  output logic       o_cfg_ready,
  input  logic [7:0] i_cfg_lo,
  input  logic [7:0] i_cfg_hi,
  input  logic       i_start,
  input  logic       i_stop,
  input  logic [7:0] i_cnt,
  output logic       o_load,
  output logic [7:0] o_load_val,
  output logic       o_dir,
  output logic       o_busy,
  output logic       o_sweep_done,
  output logic       o_err_cfg
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StLoad = 2'd1;
  localparam logic [1:0] StUp   = 2'd2;
  localparam logic [1:0] StDown = 2'd3;

  // Sweep count target in the width of the sweep counter.
  localparam logic [7:0] SweepsTgt = 8'(SWEEPS);
  localparam logic       AutoStop  = (SWEEPS != 0);

  logic [1:0] r_state;
  logic [7:0] r_lo;
  logic [7:0] r_hi;
  logic [7:0] r_hold;
  logic       r_cfg_ok;
  logic [7:0] r_sweep_cnt;
  logic       r_sweep_done;
  logic       r_err_cfg;

  logic [1:0] w_state_nxt;
  logic [7:0] w_lo_nxt;
  logic [7:0] w_hi_nxt;
  logic [7:0] w_hold_nxt;
  logic       w_cfg_ok_nxt;
  logic [7:0] w_sweep_cnt_nxt;
  logic       w_sweep_done_nxt;
  logic       w_err_cfg_nxt;

  logic       w_at_hi;
  logic       w_at_lo;
  logic [7:0] w_sweep_inc;
  logic       w_final;
  logic       w_cfg_good;
  logic [7:0] w_cnt_after;

  assign w_at_hi     = (i_cnt == r_hi);
  assign w_at_lo     = (i_cnt == r_lo);
  assign w_sweep_inc = r_sweep_cnt + 8'd1;
  assign w_final     = AutoStop && (w_sweep_inc == SweepsTgt);
  assign w_cfg_good  = (i_cfg_lo < i_cfg_hi);

  // Counter controls. The direction flips in the same cycle the counter sits
  // on a bound, so the counter never steps past lo or hi.
  always_comb begin
    o_load     = 1'b1;
    o_load_val = r_lo;
    o_dir      = 1'b1;
    case (r_state)
      StIdle: begin
        o_load_val = r_hold;
      end
      StLoad: begin
        o_load_val = r_lo;
      end
      StUp: begin
        o_load = 1'b0;
        o_dir  = ~w_at_hi;
      end
      StDown: begin
        if (w_at_lo) begin
          // Final sweep parks the counter on lo; otherwise turn around.
          o_load = w_final;
          o_dir  = 1'b1;
        end else begin
          o_load = 1'b0;
          o_dir  = 1'b0;
        end
      end
      default: begin
        o_load_val = r_hold;
      end
    endcase
  end

  // Value the counter will hold after the coming edge; captured on stop so the
  // idle load keeps the counter exactly where the abort left it.
  always_comb begin
    if (o_load) begin
      w_cnt_after = o_load_val;
    end else if (o_dir) begin
      w_cnt_after = i_cnt + 8'd1;
    end else begin
      w_cnt_after = i_cnt - 8'd1;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_lo_nxt         = r_lo;
    w_hi_nxt         = r_hi;
    w_hold_nxt       = r_hold;
    w_cfg_ok_nxt     = r_cfg_ok;
    w_sweep_cnt_nxt  = r_sweep_cnt;
    w_sweep_done_nxt = 1'b0;
    w_err_cfg_nxt    = r_err_cfg;

    case (r_state)
      StIdle: begin
        if (i_cfg_valid) begin
          // A handshake in the same cycle as start suppresses the start.
          if (w_cfg_good) begin
            w_lo_nxt      = i_cfg_lo;
            w_hi_nxt      = i_cfg_hi;
            w_cfg_ok_nxt  = 1'b1;
            w_err_cfg_nxt = 1'b0;
          end else begin
            w_err_cfg_nxt = 1'b1;
          end
        end else if (i_start && r_cfg_ok) begin
          w_state_nxt = StLoad;
        end
      end
      StLoad: begin
        w_sweep_cnt_nxt = 8'd0;
        w_state_nxt     = StUp;
      end
      StUp: begin
        if (w_at_hi) begin
          w_state_nxt = StDown;
        end
      end
      StDown: begin
        if (w_at_lo) begin
          w_sweep_done_nxt = 1'b1;
          w_sweep_cnt_nxt  = w_sweep_inc;
          if (w_final) begin
            w_hold_nxt  = r_lo;
            w_state_nxt = StIdle;
          end else begin
            w_state_nxt = StUp;
          end
        end
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase

    // Abort wins over every other transition; an interrupted sweep is not
    // reported as complete.
    if (i_stop && (r_state != StIdle)) begin
      w_state_nxt      = StIdle;
      w_hold_nxt       = w_cnt_after;
      w_sweep_cnt_nxt  = r_sweep_cnt;
      w_sweep_done_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= StIdle;
      r_lo         <= 8'd0;
      r_hi         <= 8'd0;
      r_hold       <= 8'd0;
      r_cfg_ok     <= 1'b0;
      r_sweep_cnt  <= 8'd0;
      r_sweep_done <= 1'b0;
      r_err_cfg    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_lo         <= w_lo_nxt;
      r_hi         <= w_hi_nxt;
      r_hold       <= w_hold_nxt;
      r_cfg_ok     <= w_cfg_ok_nxt;
      r_sweep_cnt  <= w_sweep_cnt_nxt;
      r_sweep_done <= w_sweep_done_nxt;
      r_err_cfg    <= w_err_cfg_nxt;
    end
  end

  assign o_cfg_ready  = (r_state == StIdle);
  assign o_busy       = (r_state != StIdle);
  assign o_sweep_done = r_sweep_done;
  assign o_err_cfg    = r_err_cfg;

endmodule

// File: tb/tb_sweep_ctrl.sv
// Bench for sweep_ctrl: two instances (free-run and SWEEPS=2) share stimulus,
// each closing the loop through a behavioural 8-bit loadable up/down counter.

module tb_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rstn;
  logic       cfg_valid;
  logic [7:0] cfg_lo;
  logic [7:0] cfg_hi;
  logic       start;
  logic       stop;

  logic       cfg_ready0, load0, dir0, busy0, done0, err0;
  logic [7:0] load_val0, cnt0;
  logic       cfg_ready2, load2, dir2, busy2, done2, err2;
  logic [7:0] load_val2, cnt2;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  sweep_ctrl #(.SWEEPS(0)) dut0 (
    .clk(clk), .rstn(rstn), .i_cfg_valid(cfg_valid), .o_cfg_ready(cfg_ready0),
    .i_cfg_lo(cfg_lo), .i_cfg_hi(cfg_hi), .i_start(start), .i_stop(stop), .i_cnt(cnt0),
    .o_load(load0), .o_load_val(load_val0), .o_dir(dir0), .o_busy(busy0),
    .o_sweep_done(done0), .o_err_cfg(err0)
  );

  sweep_ctrl #(.SWEEPS(2)) dut2 (
    .clk(clk), .rstn(rstn), .i_cfg_valid(cfg_valid), .o_cfg_ready(cfg_ready2),
    .i_cfg_lo(cfg_lo), .i_cfg_hi(cfg_hi), .i_start(start), .i_stop(stop), .i_cnt(cnt2),
    .o_load(load2), .o_load_val(load_val2), .o_dir(dir2), .o_busy(busy2),
    .o_sweep_done(done2), .o_err_cfg(err2)
  );

  // Downstream counters.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) cnt0 <= 8'd0;
    else if (load0) cnt0 <= load_val0;
    else if (dir0) cnt0 <= cnt0 + 8'd1;
    else cnt0 <= cnt0 - 8'd1;
  end

  always @(posedge clk or negedge rstn) begin
    if (!rstn) cnt2 <= 8'd0;
    else if (load2) cnt2 <= load_val2;
    else if (dir2) cnt2 <= cnt2 + 8'd1;
    else cnt2 <= cnt2 - 8'd1;
  end

  task automatic do_cfg(input logic [7:0] lo, input logic [7:0] hi);
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_lo = lo;
    cfg_hi = hi;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  // Returns on the negedge after the start edge.
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    #1;
    vectors++;
    if (busy0 !== 1'b0) begin miscompares++; $display("FAIL reset busy: got %b want 0", busy0); end
    vectors++;
    if (cfg_ready0 !== 1'b1) begin
      miscompares++; $display("FAIL reset cfg_ready: got %b want 1", cfg_ready0);
    end
    vectors++;
    if (done0 !== 1'b0 || err0 !== 1'b0) begin
      miscompares++; $display("FAIL reset flags: got done=%b err=%b want 0 0", done0, err0);
    end
    vectors++;
    if (load0 !== 1'b1 || load_val0 !== 8'd0 || dir0 !== 1'b1) begin
      miscompares++;
      $display("FAIL reset ctrl: got load=%b val=%0d dir=%b want 1 0 1", load0, load_val0, dir0);
    end
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (cnt0 !== 8'd0 || busy0 !== 1'b0) begin
        miscompares++;
        $display("FAIL reset hold[%0d]: got cnt=%0d busy=%b want 0 0", i, cnt0, busy0);
      end
    end
  endtask

  task automatic test_bad_cfg();
    logic [7:0] e_cnt [4] = '{8'd0, 8'd1, 8'd0, 8'd1};
    logic       e_done [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    do_cfg(8'd7, 8'd7);
    vectors++;
    if (err0 !== 1'b1) begin miscompares++; $display("FAIL err equal: got %b want 1", err0); end
    do_cfg(8'd9, 8'd2);
    vectors++;
    if (err0 !== 1'b1) begin miscompares++; $display("FAIL err inverted: got %b want 1", err0); end
    pulse_start();
    vectors++;
    if (busy0 !== 1'b0) begin
      miscompares++; $display("FAIL start without cfg: got busy=%b want 0", busy0);
    end
    do_cfg(8'd0, 8'd1);
    vectors++;
    if (err0 !== 1'b0) begin miscompares++; $display("FAIL err clear: got %b want 0", err0); end
    pulse_start();
    vectors++;
    if (busy0 !== 1'b1 || load0 !== 1'b1 || load_val0 !== 8'd0) begin
      miscompares++;
      $display("FAIL load 0/1: got busy=%b load=%b val=%0d want 1 1 0", busy0, load0, load_val0);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vectors++;
      if (cnt0 !== e_cnt[i] || done0 !== e_done[i]) begin
        miscompares++;
        $display("FAIL seq01[%0d]: got cnt=%0d done=%b want %0d %b", i, cnt0, done0,
                 e_cnt[i], e_done[i]);
      end
    end
    // cnt=1 in UP at hi: direction already down, so the abort parks on 0.
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    vectors++;
    if (cnt0 !== 8'd0 || busy0 !== 1'b0) begin
      miscompares++; $display("FAIL stop at hi: got cnt=%0d busy=%b want 0 0", cnt0, busy0);
    end
  endtask

  task automatic test_sweep();
    logic [7:0] e_cnt [10] = '{8'd3, 8'd4, 8'd5, 8'd4, 8'd3, 8'd4, 8'd5, 8'd4, 8'd3, 8'd4};
    logic       e_done [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    do_cfg(8'd3, 8'd5);
    pulse_start();
    vectors++;
    if (busy0 !== 1'b1 || load0 !== 1'b1 || load_val0 !== 8'd3 || cfg_ready0 !== 1'b0) begin
      miscompares++;
      $display("FAIL load 3/5: got busy=%b load=%b val=%0d rdy=%b want 1 1 3 0", busy0, load0,
               load_val0, cfg_ready0);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      vectors++;
      if (cnt0 !== e_cnt[i] || done0 !== e_done[i] || busy0 !== 1'b1) begin
        miscompares++;
        $display("FAIL seq35[%0d]: got cnt=%0d done=%b busy=%b want %0d %b 1", i, cnt0, done0,
                 busy0, e_cnt[i], e_done[i]);
      end
    end
    // Abort at cnt=4 going up: counter takes 5 and stays there.
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    vectors++;
    if (cnt0 !== 8'd5 || busy0 !== 1'b0 || cfg_ready0 !== 1'b1) begin
      miscompares++;
      $display("FAIL stop up: got cnt=%0d busy=%b rdy=%b want 5 0 1", cnt0, busy0, cfg_ready0);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      vectors++;
      if (cnt0 !== 8'd5) begin
        miscompares++; $display("FAIL stop hold[%0d]: got cnt=%0d want 5", i, cnt0);
      end
    end
  endtask

  task automatic test_auto_stop();
    logic [7:0] e_cnt [12] = '{8'd10, 8'd11, 8'd12, 8'd11, 8'd10, 8'd11, 8'd12, 8'd11, 8'd10,
                               8'd10, 8'd10, 8'd10};
    logic       e_busy [12] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                                1'b0, 1'b0, 1'b0};
    logic       e_done [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                                1'b1, 1'b0, 1'b0};
    int pulses = 0;
    do_cfg(8'd10, 8'd12);
    pulse_start();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done2 === 1'b1) pulses++;
      vectors++;
      if (cnt2 !== e_cnt[i] || busy2 !== e_busy[i] || done2 !== e_done[i]) begin
        miscompares++;
        $display("FAIL auto[%0d]: got cnt=%0d busy=%b done=%b want %0d %b %b", i, cnt2, busy2,
                 done2, e_cnt[i], e_busy[i], e_done[i]);
      end
    end
    vectors++;
    if (pulses != 2) begin
      miscompares++; $display("FAIL auto pulses: got %0d want 2", pulses);
    end
    vectors++;
    if (busy0 !== 1'b1) begin
      miscompares++; $display("FAIL free-run busy: got %b want 1", busy0);
    end
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  task automatic test_cfg_start_same_cycle();
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_lo = 8'd20;
    cfg_hi = 8'd30;
    start = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    start = 1'b0;
    vectors++;
    if (busy0 !== 1'b0 || cfg_ready0 !== 1'b1 || err0 !== 1'b0) begin
      miscompares++;
      $display("FAIL cfg+start: got busy=%b rdy=%b err=%b want 0 1 0", busy0, cfg_ready0, err0);
    end
    pulse_start();
    vectors++;
    if (busy0 !== 1'b1 || load_val0 !== 8'd20) begin
      miscompares++;
      $display("FAIL new bounds: got busy=%b val=%0d want 1 20", busy0, load_val0);
    end
    // Abort in the LOAD cycle.
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (cnt0 !== 8'd20 || busy0 !== 1'b0) begin
        miscompares++;
        $display("FAIL stop load[%0d]: got cnt=%0d busy=%b want 20 0", i, cnt0, busy0);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_sweep();
    logic [7:0] e_cnt [4] = '{8'd3, 8'd4, 8'd5, 8'd4};
    do_cfg(8'd3, 8'd5);
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vectors++;
      if (cnt0 !== e_cnt[i]) begin
        miscompares++; $display("FAIL pre-reset[%0d]: got cnt=%0d want %0d", i, cnt0, e_cnt[i]);
      end
    end
    // Now in DOWN at cnt=4.
    rstn = 1'b0;
    #1;
    vectors++;
    if (busy0 !== 1'b0 || cfg_ready0 !== 1'b1 || load0 !== 1'b1 || load_val0 !== 8'd0) begin
      miscompares++;
      $display("FAIL async reset: got busy=%b rdy=%b load=%b val=%0d want 0 1 1 0", busy0,
               cfg_ready0, load0, load_val0);
    end
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      vectors++;
      if (cnt0 !== 8'd0 || done0 !== 1'b0) begin
        miscompares++;
        $display("FAIL post-reset[%0d]: got cnt=%0d done=%b want 0 0", i, cnt0, done0);
      end
    end
    pulse_start();
    @(negedge clk);
    vectors++;
    if (busy0 !== 1'b0 || cnt0 !== 8'd0) begin
      miscompares++;
      $display("FAIL start after reset: got busy=%b cnt=%0d want 0 0", busy0, cnt0);
    end
  endtask

  initial begin
    rstn = 1'b0;
    cfg_valid = 1'b0;
    cfg_lo = 8'd0;
    cfg_hi = 8'd0;
    start = 1'b0;
    stop = 1'b0;
    test_reset();
    test_bad_cfg();
    test_sweep();
    test_auto_stop();
    test_cfg_start_same_cycle();
    test_reset_mid_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sweep_ctrl.md
# sweep_ctrl

Control stage placed directly upstream of the 8-bit loadable up/down counter. It drives the counter's `load`, `in` and `dir` inputs and reads back its `out` value, so the counter performs a triangle sweep between programmable bounds `lo` and `hi`. The block also freezes the counter when idle, counts completed sweeps, and can stop automatically after a set number of sweeps.

## Interface
- `SWEEPS`, default 0: number of full sweeps (lo→hi→lo) before auto-stop. 0 means free-run until `stop`.
- `clk`  in  1: clock, rising edge.
- `rstn`  in  1: reset, asynchronous, active-low.
- `cfg_valid`  in  1: config offer.
- `cfg_ready`  out  1: config accept. High only in IDLE.
- `cfg_lo`  in  8: lower sweep bound.
- `cfg_hi`  in  8: upper sweep bound.
- `start`  in  1: start request, single-cycle level sample.
- `stop`  in  1: abort request.
- `cnt`  in  8: counter output fed back.
- `load`  out  1: to counter `load`. Combinational from state and `cnt`.
- `load_val`  out  8: to counter `in`.
- `dir`  out  1: to counter `dir`. 1 = up. Combinational.
- `busy`  out  1: state ≠ IDLE.
- `sweep_done`  out  1: one-cycle pulse per completed sweep. Registered.
- `err_cfg`  out  1: sticky flag for a rejected config.

## Operation
- States: IDLE, LOAD, UP, DOWN.
- Reset values:
  - state = IDLE.
  - `lo`/`hi`/`hold` = 0; `cfg_ok` = 0; sweep counter = 0.
  - `sweep_done` = 0; `err_cfg` = 0; `busy` = 0.
- IDLE:
  - `load`=1, `load_val`=`hold`, `dir`=1. The counter stays frozen.
  - `cfg_ready`=1.
- Config handshake (`cfg_valid` in IDLE):
  - If `cfg_lo` < `cfg_hi` (unsigned): latch both bounds, `cfg_ok` ← 1, `err_cfg` ← 0.
  - Otherwise: `err_cfg` ← 1, and the previous bounds and `cfg_ok` are kept.
- `start` in IDLE with `cfg_ok`=1 and no config handshake in the same cycle → LOAD. In all other cases `start` is ignored.
- LOAD (one cycle): `load`=1, `load_val`=`lo`. Clear the sweep counter. Next state is UP.
- UP: `load`=0.
  - While `cnt` ≠ `hi`: `dir`=1.
  - When `cnt` == `hi`: `dir`=0, next state DOWN.
- DOWN: `load`=0.
  - While `cnt` ≠ `lo`: `dir`=0.
  - When `cnt` == `lo`, a sweep is complete:
    - `sweep_done` pulses in the next cycle.
    - The sweep counter increments.
    - If `SWEEPS` ≠ 0 and the new count == `SWEEPS` (final sweep): `load`=1, `load_val`=`lo`, `hold` ← `lo`, next state IDLE.
    - Otherwise: `dir`=1, next state UP.
- `stop` in LOAD/UP/DOWN has priority over every other transition. Next state is IDLE, and `hold` ← the counter value after that edge:
  - `lo` if in LOAD.
  - `cnt+1` if `dir`=1.
  - `cnt−1` if `dir`=0.
  - The counter freezes at that value from the next cycle.
- `stop` in IDLE: no effect.
- The block never reconfigures while busy. Bounds change only through the IDLE handshake.
- Sweep counter: 8 bits, wraps at 255 in free-run. With `SWEEPS` ≠ 0 it never passes `SWEEPS`.
- `hi`−`lo` = 1 is legal. The sequence is lo, hi, lo, hi…

## Timing
- Start to first count: the `start` edge E0 enters LOAD; the counter holds `lo` after E1; UP begins with `cnt`=`lo`.
- `dir` reverses in the same cycle that `cnt` equals the bound. The counter therefore never exceeds `hi` or goes below `lo` (no overshoot).
- Sweep period: 2·(`hi`−`lo`) cycles.
- `sweep_done` rises one cycle after the cycle in which `cnt`==`lo` in DOWN.
- `busy` and `cfg_ready` change on the clock edge that changes state.
- Reset asserted mid-sweep: the block returns to IDLE immediately (asynchronous) and all state is cleared. After release, the counter is held at 0.

## Test plan
- Reset, then config lo=3, hi=5, then `start` → `cnt` sequence 3,4,5,4,3,4,5…; `sweep_done` pulses one cycle after each `cnt`=3 seen in DOWN; `busy`=1 throughout.
- Config lo=7, hi=7, then lo=9, hi=2 → `err_cfg`=1 after the first handshake and stays 1; a subsequent `start` is ignored (`busy`=0). Then config lo=0, hi=1 → `err_cfg`=0 and `start` produces 0,1,0,1.
- `stop` asserted while `cnt`=4 in UP (lo=3, hi=5) → `cnt`=5 after that edge, then `cnt` stays 5; `busy`=0; `cfg_ready`=1.
- `SWEEPS`=2, lo=10, hi=12 → `cnt` sequence 10,11,12,11,10,11,12,11,10, then held at 10; exactly 2 `sweep_done` pulses; `busy` drops after the second return to 10.
- `start` and `cfg_valid` in the same IDLE cycle → new bounds latched, no sweep starts. `stop` in the LOAD cycle → counter holds at `lo`.
- Reset pulse during DOWN at `cnt`=4 → immediately IDLE; after release `cnt` stays 0 and `sweep_done`=0; `cfg_ok`=0, so `start` is ignored.
